// File: rtl/nv_ram_rws_pmask.sv
// 1R1W RAM model with registered read address, per-byte write mask, optional output
// register and a post-reset sequencer that zeroes every entry before traffic is accepted.
module nv_ram_rws_pmask #(
    parameter int unsigned DW         = 128,
    parameter int unsigned AW         = 6,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       ra,
    input  logic                re,
    output logic [DW-1:0]       dout,
    output logic                dout_vld,
    input  logic [AW-1:0]       wa,
    input  logic                we,
    input  logic [DW/8-1:0]     wmask,
    input  logic [DW-1:0]       di,
    output logic                ready,
    input  logic [31:0]         pwrbus_ram_pd
);

    localparam int unsigned NB      = DW / 8;
    localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [AW-1:0]   ra_q, ra_d;
    logic            rvld_q, rvld_d;

    logic [DW-1:0]   mem_q [DEPTH];

    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [DW-1:0]   wr_data;
    logic [NB-1:0]   wr_bmask;
    logic [DW-1:0]   rd_data;
    logic            wa_ok;
    logic            ra_ok;

    // Power-down bus has no functional effect in this model.
    logic unused_pwr;
    assign unused_pwr = ^pwrbus_ram_pd;

    assign wa_ok = {1'b0, wa} < DEPTH_W;
    assign ra_ok = {1'b0, ra_q} < DEPTH_W;
    assign ready = (state_q == StRun);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == StClear) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST) begin
                state_d = StRun;
            end
        end
    end

    // The clear sequencer owns the write port until every entry has been zeroed.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = wa[IW-1:0];
        wr_data  = di;
        wr_bmask = wmask;
        if (!rst) begin
            if (state_q == StClear) begin
                wr_en    = 1'b1;
                wr_idx   = clr_cnt_q;
                wr_data  = '0;
                wr_bmask = '1;
            end else begin
                wr_en = we & wa_ok;
            end
        end
    end

    always_comb begin
        rd_data = ra_ok ? mem_q[ra_q[IW-1:0]] : '0;
        ra_d    = (re && ready) ? ra : ra_q;
        rvld_d  = re & ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (INIT_CLEAR != 0) ? StClear : StRun;
            clr_cnt_q <= '0;
            ra_q      <= '0;
            rvld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ra_q      <= ra_d;
            rvld_q    <= rvld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_bmask[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DW-1:0] dout_q, dout_d;
        logic          dout_vld_q, dout_vld_d;

        // Capture only on the edge after an accepted read so dout holds between reads.
        always_comb begin
            dout_d     = rvld_q ? rd_data : dout_q;
            dout_vld_d = rvld_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q     <= '0;
                dout_vld_q <= 1'b0;
            end else begin
                dout_q     <= dout_d;
                dout_vld_q <= dout_vld_d;
            end
        end

        assign dout     = dout_q;
        assign dout_vld = dout_vld_q;
    end else begin : g_out_comb
        assign dout     = ready ? rd_data : '0;
        assign dout_vld = rvld_q;
    end

endmodule

// File: tb/tb_nv_ram_rws_pmask.sv
// Directed bench for nv_ram_rws_pmask: three instances (latency 1, latency 2, DEPTH=48)
// share one stimulus stream and are checked against hand-derived values.
module tb_nv_ram_rws_pmask;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 6;
    localparam int unsigned NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ra;
    logic          re;
    logic [AW-1:0] wa;
    logic          we;
    logic [NB-1:0] wmask;
    logic [DW-1:0] di;
    logic [31:0]   pwr;

    logic [DW-1:0] dout0, dout1, dout2;
    logic          vld0, vld1, vld2;
    logic          ready0, ready1, ready2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nv_ram_rws_pmask #(.DW(DW), .AW(AW), .DEPTH(64), .OUT_REG(0), .INIT_CLEAR(1)) u_d0 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout0), .dout_vld(vld0),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .ready(ready0), .pwrbus_ram_pd(pwr)
    );

    nv_ram_rws_pmask #(.DW(DW), .AW(AW), .DEPTH(64), .OUT_REG(1), .INIT_CLEAR(1)) u_d1 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout1), .dout_vld(vld1),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .ready(ready1), .pwrbus_ram_pd(pwr)
    );

    nv_ram_rws_pmask #(.DW(DW), .AW(AW), .DEPTH(48), .OUT_REG(0), .INIT_CLEAR(1)) u_d2 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout2), .dout_vld(vld2),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .ready(ready2), .pwrbus_ram_pd(pwr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i * 3 + 1);
        return {NB{b}};
    endfunction

    function automatic logic [DW-1:0] ev(input bit zero, input int i);
        return zero ? '0 : pat(i);
    endfunction

    // Counts post-edge cycles with ready low, starting in the state right after the last
    // rst edge; optionally drives junk re/we that must be ignored while clearing.
    task automatic clear_count(input bit junk, output int n0, output int n2, output int vseen);
        n0 = 0;
        n2 = 0;
        vseen = 0;
        for (int k = 0; k < 200; k++) begin
            if (!ready0) n0++;
            if (!ready2) n2++;
            if (vld0 || vld1) vseen++;
            if (ready0 && ready2) break;
            re    = junk && (k < 40);
            we    = junk && (k < 40);
            ra    = 6'd3;
            wa    = 6'd3;
            di    = '1;
            wmask = '1;
            tick;
        end
        re = 1'b0;
        we = 1'b0;
    endtask

    // Back-to-back reads of addresses 0..63, then re drops for two cycles.
    task automatic stream(input bit zero);
        for (int i = 0; i < 66; i++) begin
            re = (i < 64);
            ra = 6'(i);
            tick;
            if (i < 64) begin
                check("s_vld0", vld0, 1);
                check("s_dout0", dout0, ev(zero, i));
                check("s_vld2", vld2, 1);
                check("s_dout2", dout2, (i < 48) ? ev(zero, i) : '0);
            end else begin
                check("s_vld0_drop", vld0, 0);
                check("s_dout0_hold", dout0, ev(zero, 63));
                check("s_vld2_drop", vld2, 0);
            end
            if (i == 0) begin
                check("s_vld1_first", vld1, 0);
            end else if (i <= 64) begin
                check("s_vld1", vld1, 1);
                check("s_dout1", dout1, ev(zero, i - 1));
            end else begin
                check("s_vld1_drop", vld1, 0);
                check("s_dout1_hold", dout1, ev(zero, 63));
            end
        end
        re = 1'b0;
    endtask

    initial begin
        int n0, n2, vs;
        logic [DW-1:0] merged;

        rst = 1'b1; re = 1'b0; we = 1'b0; ra = '0; wa = '0;
        wmask = '0; di = '0; pwr = '0;
        tick;
        tick;
        check("rst_ready0", ready0, 0);
        check("rst_dout0", dout0, '0);
        check("rst_vld0", vld0, 0);
        check("rst_dout1", dout1, '0);
        check("rst_vld1", vld1, 0);
        rst = 1'b0;

        // Initial clear length and zero contents
        clear_count(1'b0, n0, n2, vs);
        check("clr_len64", 128'(n0), 128'd64);
        check("clr_len48", 128'(n2), 128'd48);
        check("clr_vld", 128'(vs), 128'd0);
        stream(1'b1);

        // Distinct data per entry; DEPTH=48 instance must drop writes to 48..63
        for (int i = 0; i < 64; i++) begin
            we = 1'b1; wa = 6'(i); di = pat(i); wmask = '1;
            tick;
        end
        we = 1'b0;
        stream(1'b0);

        // Byte-masked merge on entry 5
        we = 1'b1; wa = 6'd5; di = {NB{8'hA5}}; wmask = '1;
        tick;
        di = {NB{8'h3C}}; wmask = 16'h00FF;
        tick;
        we = 1'b0; re = 1'b1; ra = 6'd5;
        tick;
        re = 1'b0;
        merged = {{8{8'hA5}}, {8{8'h3C}}};
        check("mask_dout0", dout0, merged);
        check("mask_vld0", vld0, 1);
        tick;
        check("mask_dout1", dout1, merged);
        check("mask_vld1", vld1, 1);
        we = 1'b1; wa = 6'd5; di = '0; wmask = '0;
        tick;
        we = 1'b0;
        check("nomask_dout0", dout0, merged);

        // Same-edge write/read collision, then a write at N+1
        we = 1'b1; wa = 6'd9; di = 128'h1234; wmask = '1; re = 1'b1; ra = 6'd9;
        tick;
        check("col_dout0", dout0, 128'h1234);
        check("col_vld0", vld0, 1);
        re = 1'b0; di = {NB{8'h55}};
        tick;
        we = 1'b0;
        check("col_dout1", dout1, 128'h1234);
        check("col_vld1", vld1, 1);
        check("col_live0", dout0, {NB{8'h55}});
        check("col_vld0_off", vld0, 0);
        tick;
        check("col_hold1", dout1, 128'h1234);
        check("col_vld1_off", vld1, 0);

        // Reset mid-clear restarts the clear; traffic during clear is ignored
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst2_dout0", dout0, '0);
        check("rst2_dout1", dout1, '0);
        check("rst2_ready0", ready0, 0);
        for (int k = 0; k < 30; k++) begin
            re = 1'b1; we = 1'b1; ra = 6'd3; wa = 6'd3; di = '1; wmask = '1;
            tick;
        end
        re = 1'b0; we = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clear_count(1'b1, n0, n2, vs);
        check("reclr_len64", 128'(n0), 128'd64);
        check("reclr_len48", 128'(n2), 128'd48);
        check("reclr_vld", 128'(vs), 128'd0);
        stream(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
